// File: rtl/tri_feed_pkg.sv
// Shared types and constants for the rasterizer front end.
// Triangle/color layouts, FIFO sizing and sub-sample encodings.
package tri_feed_pkg;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned RADIX  = 10;
  localparam int unsigned VERTS  = 3;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;

  localparam int unsigned PIPES_BOX  = 3;
  localparam int unsigned PIPES_ITER = 1;
  localparam int unsigned PIPES_HASH = 2;
  localparam int unsigned PIPES_SAMP = 2;

  localparam int unsigned FEED_DEPTH = 4;

  // One-hot MSAA codes: samples per pixel.
  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  typedef logic signed [SIGFIG-1:0] fix_t;
  typedef fix_t [AXIS-1:0]          vertex_t;
  typedef vertex_t [VERTS-1:0]      tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;
  typedef fix_t [1:0]               screen_t;

  typedef struct packed {
    tri_t   vtx;
    color_t col;
  } feed_t;

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} feed_state_e;

  function automatic logic is_onehot4(logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/tri_feed_fifo.sv
// Synchronous FIFO of triangle+color entries with registered occupancy.
// Push when full and pop when empty are ignored.
module tri_feed_fifo
  import tri_feed_pkg::*;
#(
  parameter int unsigned Depth = FEED_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  feed_t                  wdata,
  output feed_t                  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned AW = $clog2(Depth);

  feed_t           mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == (AW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tri_feed.sv
// Triangle feeder: buffers upstream triangles and presents them to the
// rasterizer under halt backpressure; owns screen/sub-sample config.
module tri_feed
  import tri_feed_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FEED_DEPTH,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  tri_t             in_tri_S,
  input  color_t           in_color_U,
  input  logic             in_valid_H,
  input  logic             in_last_H,
  output logic             in_ready_H,
  input  logic             cfg_load_H,
  input  screen_t          cfg_screen_S,
  input  logic [3:0]       cfg_subSample_U,
  output tri_t             tri_R10S,
  output color_t           color_R10U,
  output logic             validTri_R10H,
  input  logic             halt_RnnnnL,
  output screen_t          screen_RnnnnS,
  output logic [3:0]       subSample_RnnnnU,
  output logic             frame_done_H,
  output logic [CNT_W-1:0] tri_count_U,
  output logic             busy_H
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  feed_state_e      state_q, state_d;
  logic             rdy_en_q;
  feed_t            out_q, out_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q;
  screen_t          screen_q;
  logic [3:0]       ss_q;

  feed_t            in_beat, fifo_rdata;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             in_xfer, out_xfer, out_free, bypass, cfg_take;

  assign in_beat  = {in_tri_S, in_color_U};
  assign in_xfer  = in_valid_H & in_ready_H;
  assign out_xfer = valid_q & halt_RnnnnL;
  assign out_free = ~valid_q | halt_RnnnnL;
  // With nothing queued ahead, an accepted beat skips the FIFO entirely.
  assign bypass    = fifo_empty & out_free;
  assign fifo_push = in_xfer & ~bypass & ~fifo_full;
  assign fifo_pop  = out_free & ~fifo_empty;
  assign cfg_take  = cfg_load_H & (state_q == StIdle) & is_onehot4(cfg_subSample_U);

  tri_feed_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_beat),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_xfer) state_d = in_last_H ? StDrain : StStream;
      StStream: if (in_xfer && in_last_H) state_d = StDrain;
      StDrain:  if (fifo_empty && out_free) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_H   = rdy_en_q & ((state_q == StIdle) | (state_q == StStream)) &
                   (fifo_count < CW'(FIFO_DEPTH));
    frame_done_H = (state_q == StDone);
    busy_H       = (state_q != StIdle);
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (out_free) begin
      if (!fifo_empty) begin
        out_d   = fifo_rdata;
        valid_d = 1'b1;
      end else if (in_xfer) begin
        out_d   = in_beat;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      cnt_q    <= '0;
      screen_q <= '0;
      ss_q     <= SS_1X;
    end else begin
      rdy_en_q <= 1'b1;
      valid_q  <= valid_d;
      out_q    <= out_d;
      if (out_xfer) cnt_q <= cnt_q + CNT_W'(1);
      if (cfg_take) begin
        screen_q <= cfg_screen_S;
        ss_q     <= cfg_subSample_U;
      end
    end
  end

  assign tri_R10S         = out_q.vtx;
  assign color_R10U       = out_q.col;
  assign validTri_R10H    = valid_q;
  assign screen_RnnnnS    = screen_q;
  assign subSample_RnnnnU = ss_q;
  assign tri_count_U      = cnt_q;

endmodule

// File: tb/tb_tri_feed.sv
// Bench for tri_feed: random triangles checked against an ordered
// accept/deliver model, plus config, halt, reset and wrap scenarios.
module tb_tri_feed;
  import tri_feed_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tri_t             in_tri_S;
  color_t           in_color_U;
  logic             in_valid_H, in_last_H, in_ready_H, cfg_load_H;
  screen_t          cfg_screen_S;
  logic [3:0]       cfg_subSample_U;
  tri_t             tri_R10S;
  color_t           color_R10U;
  logic             validTri_R10H, halt_RnnnnL;
  screen_t          screen_RnnnnS;
  logic [3:0]       subSample_RnnnnU;
  logic             frame_done_H, busy_H;
  logic [CNT_W-1:0] tri_count_U;

  tri_feed #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_tri_S         (in_tri_S),
    .in_color_U       (in_color_U),
    .in_valid_H       (in_valid_H),
    .in_last_H        (in_last_H),
    .in_ready_H       (in_ready_H),
    .cfg_load_H       (cfg_load_H),
    .cfg_screen_S     (cfg_screen_S),
    .cfg_subSample_U  (cfg_subSample_U),
    .tri_R10S         (tri_R10S),
    .color_R10U       (color_R10U),
    .validTri_R10H    (validTri_R10H),
    .halt_RnnnnL      (halt_RnnnnL),
    .screen_RnnnnS    (screen_RnnnnS),
    .subSample_RnnnnU (subSample_RnnnnU),
    .frame_done_H     (frame_done_H),
    .tri_count_U      (tri_count_U),
    .busy_H           (busy_H)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_n = 0;
  int done_cyc = -1;
  int last_xfer_cyc = -1;
  feed_t acc_q[$];
  feed_t got_q[$];
  logic [CNT_W-1:0] acc_total;
  screen_t exp_screen;
  logic [3:0] exp_ss;

  function automatic feed_t rand_feed();
    feed_t f;
    for (int i = 0; i < $bits(feed_t); i++) f[i] = 1'($urandom_range(1, 0));
    return f;
  endfunction

  function automatic int seq_errs();
    int e = 0;
    if (got_q.size() != acc_q.size()) e++;
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++)
      if (got_q[i] !== acc_q[i]) e++;
    return e;
  endfunction

  task automatic drive_beat(input logic last);
    feed_t b;
    b = rand_feed();
    in_tri_S   = b.vtx;
    in_color_U = b.col;
    in_valid_H = 1'b1;
    in_last_H  = last;
  endtask

  task automatic idle_in();
    in_valid_H = 1'b0;
    in_last_H  = 1'b0;
    cfg_load_H = 1'b0;
  endtask

  task automatic clear_model();
    acc_q.delete();
    got_q.delete();
  endtask

  // Record what the upcoming edge will transfer, then advance one cycle.
  task automatic tick();
    feed_t g;
    if (in_valid_H === 1'b1 && in_ready_H === 1'b1) begin
      g.vtx = in_tri_S;
      g.col = in_color_U;
      acc_q.push_back(g);
      acc_total = acc_total + 1'b1;
    end
    if (validTri_R10H === 1'b1 && halt_RnnnnL === 1'b1) begin
      g.vtx = tri_R10S;
      g.col = color_R10U;
      got_q.push_back(g);
      last_xfer_cyc = cyc;
    end
    if (frame_done_H === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_n;
    for (int i = 0; i < budget && done_n == start; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    halt_RnnnnL = 1'b1;
    idle_in();
    cfg_screen_S = '0;
    cfg_subSample_U = SS_1X;
    drive_beat(1'b0);
    in_valid_H = 1'b0;
    tick();
    tick();
    total += 9;
    if (validTri_R10H !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", validTri_R10H); end
    if (in_ready_H !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", in_ready_H); end
    if (tri_R10S !== '0) begin bad++; $display("FAIL rst_tri: got %h want 0", tri_R10S); end
    if (color_R10U !== '0) begin bad++; $display("FAIL rst_color: got %h want 0", color_R10U); end
    if (screen_RnnnnS !== '0) begin bad++; $display("FAIL rst_screen: got %h want 0", screen_RnnnnS); end
    if (subSample_RnnnnU !== 4'b1000) begin bad++; $display("FAIL rst_ss: got %b want 1000", subSample_RnnnnU); end
    if (tri_count_U !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", tri_count_U); end
    if (frame_done_H !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done_H); end
    if (busy_H !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_H); end
    rst = 1'b1;
    acc_total = '0;
    exp_screen = '0;
    exp_ss = 4'b1000;
    clear_model();
    tick();
    total++;
    if (in_ready_H !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %b want 1", in_ready_H); end
  endtask

  task automatic test_config();
    cfg_load_H = 1'b1;
    cfg_screen_S[0] = 24'sd1024;
    cfg_screen_S[1] = 24'sd768;
    cfg_subSample_U = 4'b0100;
    tick();
    cfg_load_H = 1'b0;
    exp_screen[0] = 24'sd1024;
    exp_screen[1] = 24'sd768;
    exp_ss = 4'b0100;
    total += 4;
    if (screen_RnnnnS !== exp_screen) begin bad++; $display("FAIL cfg_screen: got %h want %h", screen_RnnnnS, exp_screen); end
    if (subSample_RnnnnU !== exp_ss) begin bad++; $display("FAIL cfg_ss: got %b want %b", subSample_RnnnnU, exp_ss); end
    if (busy_H !== 1'b0) begin bad++; $display("FAIL cfg_busy: got %b want 0", busy_H); end
    if (in_ready_H !== 1'b1) begin bad++; $display("FAIL cfg_ready: got %b want 1", in_ready_H); end
    // Not one-hot: must be rejected even in IDLE.
    cfg_load_H = 1'b1;
    cfg_screen_S[0] = 24'sd77;
    cfg_subSample_U = 4'b0110;
    tick();
    cfg_load_H = 1'b0;
    total += 2;
    if (screen_RnnnnS !== exp_screen) begin bad++; $display("FAIL cfg_bad_screen: got %h want %h", screen_RnnnnS, exp_screen); end
    if (subSample_RnnnnU !== exp_ss) begin bad++; $display("FAIL cfg_bad_ss: got %b want %b", subSample_RnnnnU, exp_ss); end
  endtask

  task automatic test_stream();
    int nv = 0, first_v = -1, last_v = -1, start;
    clear_model();
    start = done_n;
    halt_RnnnnL = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_beat(i == 7);
      total++;
      if (in_ready_H !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready_H); end
      if (validTri_R10H === 1'b1) begin nv++; if (first_v < 0) first_v = cyc; last_v = cyc; end
      tick();
    end
    idle_in();
    for (int i = 0; i < 6; i++) begin
      if (validTri_R10H === 1'b1) begin nv++; if (first_v < 0) first_v = cyc; last_v = cyc; end
      tick();
    end
    total += 6;
    if (nv != 8) begin bad++; $display("FAIL stream_nvalid: got %0d want 8", nv); end
    if (last_v - first_v != 7) begin bad++; $display("FAIL stream_consec: got span %0d want 7", last_v - first_v); end
    if (seq_errs() != 0) begin bad++; $display("FAIL stream_order: got %0d out want %0d", got_q.size(), acc_q.size()); end
    if (tri_count_U !== acc_total) begin bad++; $display("FAIL stream_count: got %0d want %0d", tri_count_U, acc_total); end
    if (done_n != start + 1) begin bad++; $display("FAIL stream_done_n: got %0d want %0d", done_n - start, 1); end
    if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL stream_done_lat: got %0d want %0d", done_cyc, last_xfer_cyc + 1); end
  endtask

  task automatic test_halt();
    int n_acc = 0, k = 0, start;
    logic have_prev = 1'b0;
    feed_t prev, cur;
    clear_model();
    start = done_n;
    halt_RnnnnL = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_beat(1'b0);
      cur.vtx = tri_R10S;
      cur.col = color_R10U;
      if (have_prev) begin
        total++;
        if (validTri_R10H !== 1'b1 || cur !== prev) begin
          bad++; $display("FAIL halt_stable[%0d]: got %b/%h want 1/%h", i, validTri_R10H, cur, prev);
        end
      end
      if (validTri_R10H === 1'b1) begin have_prev = 1'b1; prev = cur; end
      if (in_ready_H === 1'b1) n_acc++;
      tick();
    end
    total += 3;
    if (n_acc != 5) begin bad++; $display("FAIL halt_accepts: got %0d want 5", n_acc); end
    if (in_ready_H !== 1'b0) begin bad++; $display("FAIL halt_ready: got %b want 0", in_ready_H); end
    if (got_q.size() != 0) begin bad++; $display("FAIL halt_no_xfer: got %0d want 0", got_q.size()); end
    halt_RnnnnL = 1'b1;
    for (int i = 0; i < 40 && k < 3; i++) begin
      drive_beat(k == 2);
      if (in_ready_H === 1'b1) k++;
      tick();
    end
    idle_in();
    wait_done(40);
    total += 4;
    if (done_n != start + 1) begin bad++; $display("FAIL halt_done: got %0d want 1", done_n - start); end
    if (acc_q.size() != 8) begin bad++; $display("FAIL halt_acc: got %0d want 8", acc_q.size()); end
    if (seq_errs() != 0) begin bad++; $display("FAIL halt_order: got %0d out want %0d", got_q.size(), acc_q.size()); end
    if (tri_count_U !== acc_total) begin bad++; $display("FAIL halt_count: got %0d want %0d", tri_count_U, acc_total); end
  endtask

  task automatic test_cfg_ignore();
    int start;
    clear_model();
    start = done_n;
    halt_RnnnnL = 1'b1;
    drive_beat(1'b0);
    tick();
    idle_in();
    total++;
    if (busy_H !== 1'b1) begin bad++; $display("FAIL cfgi_busy: got %b want 1", busy_H); end
    cfg_load_H = 1'b1;
    cfg_screen_S[0] = 24'sd640;
    cfg_screen_S[1] = 24'sd480;
    cfg_subSample_U = SS_64X;
    tick();
    cfg_load_H = 1'b0;
    total += 2;
    if (screen_RnnnnS !== exp_screen) begin bad++; $display("FAIL cfgi_screen: got %h want %h", screen_RnnnnS, exp_screen); end
    if (subSample_RnnnnU !== exp_ss) begin bad++; $display("FAIL cfgi_ss: got %b want %b", subSample_RnnnnU, exp_ss); end
    drive_beat(1'b1);
    total++;
    if (in_ready_H !== 1'b1) begin bad++; $display("FAIL cfgi_ready: got %b want 1", in_ready_H); end
    tick();
    idle_in();
    wait_done(20);
    total += 3;
    if (done_n != start + 1) begin bad++; $display("FAIL cfgi_done: got %0d want 1", done_n - start); end
    if (seq_errs() != 0) begin bad++; $display("FAIL cfgi_order: got %0d out want %0d", got_q.size(), acc_q.size()); end
    if (tri_count_U !== acc_total) begin bad++; $display("FAIL cfgi_count: got %0d want %0d", tri_count_U, acc_total); end
  endtask

  task automatic test_back_to_back();
    int k = 0, start;
    clear_model();
    start = done_n;
    for (int i = 0; i < 400 && k < 20; i++) begin
      halt_RnnnnL = 1'($urandom_range(3, 0) != 0);
      if ($urandom_range(3, 0) != 0) drive_beat(k == 19);
      else idle_in();
      if (in_valid_H && in_ready_H === 1'b1) k++;
      tick();
    end
    idle_in();
    halt_RnnnnL = 1'b1;
    wait_done(40);
    total += 5;
    if (k != 20) begin bad++; $display("FAIL b2b_accepted: got %0d want 20", k); end
    if (done_n != start + 1) begin bad++; $display("FAIL b2b_done: got %0d want 1", done_n - start); end
    if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL b2b_done_lat: got %0d want %0d", done_cyc, last_xfer_cyc + 1); end
    if (seq_errs() != 0) begin bad++; $display("FAIL b2b_order: got %0d out want %0d", got_q.size(), acc_q.size()); end
    if (tri_count_U !== acc_total) begin bad++; $display("FAIL b2b_count: got %0d want %0d", tri_count_U, acc_total); end
  endtask

  task automatic test_reset_drain();
    int dn;
    clear_model();
    halt_RnnnnL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(i == 3);
      tick();
    end
    idle_in();
    total += 2;
    if (busy_H !== 1'b1) begin bad++; $display("FAIL rstd_busy_pre: got %b want 1", busy_H); end
    if (validTri_R10H !== 1'b1) begin bad++; $display("FAIL rstd_valid_pre: got %b want 1", validTri_R10H); end
    dn = done_n;
    rst = 1'b0;
    tick();
    total += 5;
    if (validTri_R10H !== 1'b0) begin bad++; $display("FAIL rstd_valid: got %b want 0", validTri_R10H); end
    if (tri_count_U !== '0) begin bad++; $display("FAIL rstd_count: got %0d want 0", tri_count_U); end
    if (frame_done_H !== 1'b0) begin bad++; $display("FAIL rstd_done: got %b want 0", frame_done_H); end
    if (busy_H !== 1'b0) begin bad++; $display("FAIL rstd_busy: got %b want 0", busy_H); end
    if (subSample_RnnnnU !== 4'b1000) begin bad++; $display("FAIL rstd_ss: got %b want 1000", subSample_RnnnnU); end
    rst = 1'b1;
    halt_RnnnnL = 1'b1;
    acc_total = '0;
    exp_screen = '0;
    exp_ss = 4'b1000;
    clear_model();
    for (int i = 0; i < 6; i++) tick();
    total += 3;
    if (done_n != dn) begin bad++; $display("FAIL rstd_no_pulse: got %0d want 0", done_n - dn); end
    if (got_q.size() != 0) begin bad++; $display("FAIL rstd_discard: got %0d want 0", got_q.size()); end
    if (validTri_R10H !== 1'b0) begin bad++; $display("FAIL rstd_valid_post: got %b want 0", validTri_R10H); end
  endtask

  task automatic test_wrap();
    int start;
    clear_model();
    start = done_n;
    idle_in();
    halt_RnnnnL = 1'b1;
    force dut.cnt_q = '1;
    tick();
    release dut.cnt_q;
    acc_total = '1;
    total++;
    if (tri_count_U !== acc_total) begin bad++; $display("FAIL wrap_preload: got %h want %h", tri_count_U, acc_total); end
    drive_beat(1'b1);
    tick();
    idle_in();
    wait_done(10);
    total += 3;
    if (tri_count_U !== acc_total) begin bad++; $display("FAIL wrap_count: got %h want %h", tri_count_U, acc_total); end
    if (seq_errs() != 0) begin bad++; $display("FAIL wrap_order: got %0d out want %0d", got_q.size(), acc_q.size()); end
    if (done_n != start + 1) begin bad++; $display("FAIL wrap_done: got %0d want 1", done_n - start); end
  endtask

  initial begin
    acc_total = '0;
    test_reset();
    test_config();
    test_stream();
    test_halt();
    test_cfg_ignore();
    test_back_to_back();
    test_reset_drain();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
